huffman_seq: RTL and testbench

- Central sequencer for the 6-symbol Huffman datapath: counter, sorter/PE, count memory, min memory and encoder.
- Tracks the gray-sample stream and runs the symbol-count, combine (merge) and split (code-assign) phases.
- Drives all datapath enables and the round address, and produces the CNT_valid and code_valid pulses.
- Pure control: no datapath arithmetic. Replaces ad-hoc phase logic with one FSM that has parameterised round timing.

---
 rtl/huffman_seq_pkg.sv | 30 +++
 rtl/huffman_seq_if.sv | 39 +++
 rtl/huffman_round_ctr.sv | 56 +++++
 rtl/huffman_seq.sv | 105 ++++++++++
 tb/tb_huffman_seq.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/huffman_seq_pkg.sv
// ============================================================================
// Module : huffman_pkg
// Brief  : State encodings and shared constants for the Huffman sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package huffman_pkg;

    localparam int C_NSYM_DEF = 6;

    // Round address must reach NSYM-2 (last combine round index).
    function automatic int addr_w_for(input int nsym);
        return (nsym > 2) ? $clog2(nsym - 1) : 1;
    endfunction

    localparam int C_ADDR_W_DEF = addr_w_for(C_NSYM_DEF);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COUNT   = 3'd1,
        ST_REPORT  = 3'd2,
        ST_COMBINE = 3'd3,
        ST_SPLIT   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/huffman_seq_if.sv
// ============================================================================
// Module : huffman_seq_if
// Brief  : Sample strobe in, datapath enables/status out of the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface huffman_seq_if
    import huffman_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W_DEF
);
    logic              gray_valid;
    logic [2:0]        state;
    logic [ADDR_W-1:0] counter;
    logic              cnt_en;
    logic              sort_en;
    logic              mem_we;
    logic              enc_en;
    logic              CNT_valid;
    logic              code_valid;
    logic              busy;
    logic              ovf;
    logic              drop;

    modport master (
        input  gray_valid,
        output state, counter, cnt_en, sort_en, mem_we, enc_en,
               CNT_valid, code_valid, busy, ovf, drop
    );

    modport slave (
        output gray_valid,
        input  state, counter, cnt_en, sort_en, mem_we, enc_en,
               CNT_valid, code_valid, busy, ovf, drop
    );
endinterface

`default_nettype wire

// File: rtl/huffman_round_ctr.sv
// ============================================================================
// Module : huffman_round_ctr
// Brief  : Round address counter (up in combine, down in split) with sub-cycle divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module huffman_round_ctr #(
    parameter int NSYM     = 6,
    parameter int SORT_LAT = 1,
    parameter int ADDR_W   = 3
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_clr,
    input  wire logic              i_up,
    input  wire logic              i_dn,
    output logic [ADDR_W-1:0]      o_counter,
    output logic                   o_wr_tick,
    output logic                   o_top,
    output logic                   o_zero
);
    localparam int                C_SUB_W    = (SORT_LAT > 1) ? $clog2(SORT_LAT) : 1;
    localparam logic [C_SUB_W-1:0] C_SUB_LAST = C_SUB_W'(SORT_LAT - 1);
    localparam logic [ADDR_W-1:0]  C_TOP      = ADDR_W'(NSYM - 2);

    logic [ADDR_W-1:0]  r_ctr;
    logic [C_SUB_W-1:0] r_sub;

    assign o_counter = r_ctr;
    assign o_wr_tick = i_up && (r_sub == C_SUB_LAST);
    assign o_top     = (r_ctr == C_TOP);
    assign o_zero    = (r_ctr == '0);

    // Saturates at both ends so the address never leaves 0..NSYM-2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctr <= '0;
            r_sub <= '0;
        end else if (i_clr) begin
            r_ctr <= '0;
            r_sub <= '0;
        end else if (i_up) begin
            if (r_sub == C_SUB_LAST) begin
                r_sub <= '0;
                if (!o_top) r_ctr <= r_ctr + 1'b1;
            end else begin
                r_sub <= r_sub + 1'b1;
            end
        end else if (i_dn) begin
            if (!o_zero) r_ctr <= r_ctr - 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: rtl/huffman_seq.sv
// ============================================================================
// Module : huffman_seq
// Brief  : Phase sequencer for the 6-symbol Huffman datapath (count/combine/split).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module huffman_seq
    import huffman_pkg::*;
#(
    parameter int NSYM        = C_NSYM_DEF,
    parameter int SORT_LAT    = 1,
    parameter int ADDR_W      = C_ADDR_W_DEF,
    parameter int MAX_SAMPLES = 255
) (
    input  wire logic      clk,
    input  wire logic      reset,
    huffman_seq_if.master  bus
);
    localparam int                 C_SCNT_W      = $clog2(MAX_SAMPLES + 1);
    localparam logic [C_SCNT_W-1:0] C_LAST_ACCEPT = C_SCNT_W'(MAX_SAMPLES - 1);

    state_t              r_state, w_state_nxt;
    logic [C_SCNT_W-1:0] r_scnt, w_scnt_nxt;
    logic                r_ovf, w_ovf_nxt;
    logic                w_accept;
    logic                w_wr_tick, w_top, w_zero;
    logic [ADDR_W-1:0]   w_counter;

    huffman_round_ctr #(
        .NSYM     (NSYM),
        .SORT_LAT (SORT_LAT),
        .ADDR_W   (ADDR_W)
    ) u_round_ctr (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (!(r_state == ST_COMBINE || r_state == ST_SPLIT)),
        .i_up      (r_state == ST_COMBINE),
        .i_dn      (r_state == ST_SPLIT),
        .o_counter (w_counter),
        .o_wr_tick (w_wr_tick),
        .o_top     (w_top),
        .o_zero    (w_zero)
    );

    assign w_accept = bus.gray_valid && (r_state == ST_IDLE || r_state == ST_COUNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_scnt  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = r_scnt;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            ST_IDLE: begin
                if (bus.gray_valid) begin
                    w_state_nxt = ST_COUNT;
                    w_scnt_nxt  = C_SCNT_W'(1);
                    w_ovf_nxt   = 1'b0;
                end
            end
            ST_COUNT: begin
                if (!bus.gray_valid) begin
                    w_state_nxt = ST_REPORT;
                end else begin
                    w_scnt_nxt = r_scnt + 1'b1;
                    // This sample is number MAX_SAMPLES: close the burst.
                    if (r_scnt == C_LAST_ACCEPT) begin
                        w_state_nxt = ST_REPORT;
                        w_ovf_nxt   = 1'b1;
                    end
                end
            end
            ST_REPORT:  w_state_nxt = ST_COMBINE;
            ST_COMBINE: if (w_wr_tick && w_top) w_state_nxt = ST_SPLIT;
            ST_SPLIT:   if (w_zero) w_state_nxt = ST_DONE;
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.state      = r_state;
    assign bus.counter    = w_counter;
    assign bus.cnt_en     = w_accept;
    assign bus.drop       = bus.gray_valid && !w_accept;
    assign bus.sort_en    = (r_state == ST_COMBINE);
    assign bus.mem_we     = w_wr_tick;
    assign bus.enc_en     = (r_state == ST_SPLIT);
    assign bus.CNT_valid  = (r_state == ST_REPORT);
    assign bus.code_valid = (r_state == ST_DONE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.ovf        = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_huffman_seq.sv
// ============================================================================
// Module : tb_huffman_seq
// Brief  : Directed-vector bench for huffman_seq (SORT_LAT=1 and SORT_LAT=3 instances).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_huffman_seq;
    import huffman_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    huffman_seq_if #(.ADDR_W(3)) ifa ();
    huffman_seq_if #(.ADDR_W(3)) ifb ();

    huffman_seq #(.NSYM(6), .SORT_LAT(1), .ADDR_W(3), .MAX_SAMPLES(255)) u_dut_a (
        .clk (clk), .reset (rst_a), .bus (ifa)
    );
    huffman_seq #(.NSYM(6), .SORT_LAT(3), .ADDR_W(3), .MAX_SAMPLES(255)) u_dut_b (
        .clk (clk), .reset (rst_b), .bus (ifb)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // 10-sample burst on instance A; optional stray pulse and back-to-back restart.
    task automatic run_a(input int pulse_c, input bit b2b);
        int es, ec;
        for (int c = 0; c < 26; c++) begin
            @(posedge clk); #1;
            ifa.gray_valid = (c < 10) || (c == pulse_c) || (b2b && (c == 22 || c == 23));
            @(negedge clk);
            if (c == 0)                es = 0;
            else if (c <= 10)          es = 1;
            else if (c == 11)          es = 2;
            else if (c <= 16)          es = 3;
            else if (c <= 21)          es = 4;
            else if (c == 22)          es = 5;
            else if (b2b && c == 24)   es = 1;
            else if (b2b && c == 25)   es = 2;
            else                       es = 0;
            ec = (c >= 12 && c <= 16) ? c - 12 : (c >= 17 && c <= 21) ? 21 - c : 0;
            chk("a_state",   ifa.state,      es);
            chk("a_counter", ifa.counter,    ec);
            chk("a_busy",    ifa.busy,       es != 0);
            chk("a_cntv",    ifa.CNT_valid,  c == 11 || (b2b && c == 25));
            chk("a_sort",    ifa.sort_en,    c >= 12 && c <= 16);
            chk("a_we",      ifa.mem_we,     c >= 12 && c <= 16);
            chk("a_enc",     ifa.enc_en,     c >= 17 && c <= 21);
            chk("a_codev",   ifa.code_valid, c == 22);
            chk("a_cnt_en",  ifa.cnt_en,     (c < 10) || (b2b && c == 23));
            chk("a_drop",    ifa.drop,       (c == pulse_c) || (b2b && c == 22));
            if (c == 5) chk("a_ovf", ifa.ovf, 0);
        end
        ifa.gray_valid = 1'b0;
        for (int k = 0; k < 40 && ifa.busy; k++) @(negedge clk);
        chk("a_drain", ifa.busy, 0);
    endtask

    initial begin
        int ne;
        rst_a = 1'b0;
        rst_b = 1'b0;
        ifa.gray_valid = 1'b0;
        ifb.gray_valid = 1'b0;
        #12;
        chk("rst_a_outs", {ifa.state, ifa.counter, ifa.cnt_en, ifa.sort_en, ifa.mem_we, ifa.enc_en,
                           ifa.CNT_valid, ifa.code_valid, ifa.busy, ifa.ovf, ifa.drop}, 0);
        chk("rst_b_outs", {ifb.state, ifb.counter, ifb.cnt_en, ifb.sort_en, ifb.mem_we, ifb.enc_en,
                           ifb.CNT_valid, ifb.code_valid, ifb.busy, ifb.ovf, ifb.drop}, 0);
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Nominal 10-sample burst.
        run_a(-1, 1'b0);

        // SORT_LAT=3, single sample.
        for (int c = 0; c < 26; c++) begin
            @(posedge clk); #1;
            ifb.gray_valid = (c == 0);
            @(negedge clk);
            chk("b_cntv",    ifb.CNT_valid,  c == 2);
            chk("b_sort",    ifb.sort_en,    c >= 3 && c <= 17);
            chk("b_we",      ifb.mem_we,     c >= 5 && c <= 17 && ((c - 5) % 3) == 0);
            chk("b_counter", ifb.counter,    (c >= 3 && c <= 17) ? (c - 3) / 3 :
                                             (c >= 18 && c <= 22) ? 22 - c : 0);
            chk("b_enc",     ifb.enc_en,     c >= 18 && c <= 22);
            chk("b_codev",   ifb.code_valid, c == 23);
            chk("b_busy",    ifb.busy,       c >= 1 && c <= 23);
        end

        // gray_valid held 300 cycles: forced end at sample 255, then a 33-sample burst.
        ne = 0;
        for (int c = 0; c < 320; c++) begin
            @(posedge clk); #1;
            ifa.gray_valid = (c < 300);
            @(negedge clk);
            if (c <= 266) ne += int'(ifa.cnt_en);
            chk("ov_cnt_en", ifa.cnt_en,     (c < 255) || (c >= 267 && c < 300));
            chk("ov_drop",   ifa.drop,       c >= 255 && c <= 266);
            chk("ov_cntv",   ifa.CNT_valid,  c == 255 || c == 301);
            chk("ov_codev",  ifa.code_valid, c == 266 || c == 312);
            chk("ov_flag",   ifa.ovf,        c >= 255 && c <= 267);
        end
        chk("ov_accepted", ne, 255);
        ifa.gray_valid = 1'b0;

        // Stray sample during COMBINE: dropped, timing unchanged.
        run_a(14, 1'b0);

        // Reset asserted in SPLIT with counter=2.
        for (int c = 0; c < 19; c++) begin
            @(posedge clk); #1;
            ifa.gray_valid = (c < 10);
        end
        @(posedge clk); #1;
        chk("rs_pre_ctr", ifa.counter, 2);
        chk("rs_pre_enc", ifa.enc_en, 1);
        #2 rst_a = 1'b0;
        #1;
        chk("rs_outs", {ifa.state, ifa.counter, ifa.cnt_en, ifa.sort_en, ifa.mem_we, ifa.enc_en,
                        ifa.CNT_valid, ifa.code_valid, ifa.busy, ifa.ovf, ifa.drop}, 0);
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk("rs_no_codev", ifa.code_valid, 0);
            chk("rs_idle", ifa.busy, 0);
        end
        run_a(-1, 1'b0);

        // Back-to-back: sample in DONE dropped, next cycle restarts from IDLE.
        run_a(-1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
